fifo_read_packer: RTL and testbench
===================================

Name: fifo_read_packer

Overview:
- Sits directly downstream of the async FIFO read port, in the read-clock domain.
- Pops DATA_WIDTH-bit words from the FIFO and packs PACK consecutive words into one wide output beat.
- Presents each beat on a valid/ready interface.
- A partially filled beat is emitted on an explicit flush, or after TIMEOUT idle cycles, with a count of the valid lanes.

Parameters:
- DATA_WIDTH, 8: width of one FIFO word.
- PACK, 4: words per output beat (>=2).
- TIMEOUT, 16: consecutive no-pop cycles with a partial beat before a forced emit (>=2).

Ports:
- rclk  in  1  read-domain clock, all logic on rising edge.
- rrst  in  1  asynchronous, active-high reset.
- rempty  in  1  FIFO empty flag; low means rdata is valid (first-word-fall-through).
- rdata  in  DATA_WIDTH  FIFO head word.
- rinc  out  1  pop strobe to FIFO; head is consumed on any edge with rinc=1.
- flush  in  1  request emit of the current partial beat.
- out_data  out  DATA_WIDTH*PACK  packed beat; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_cnt  out  $clog2(PACK+1)  number of valid lanes in out_data (1..PACK).
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat when out_valid&&out_ready.

Behaviour:
- Reset (async assert, sync release):
  - state=FILL; lane index idx=0; idle counter=0.
  - out_valid=0, out_data=0, out_cnt=0, rinc=0.
- Two states: FILL and HOLD.

FILL:
- rinc = !rempty (combinational from rempty and state, registered state only); never 1 while rempty=1.
- On a pop, rdata is written into lane idx and idx increments.
- A pop with idx==PACK-1:
  - Next cycle: state=HOLD, out_valid=1, out_cnt=PACK, idx=0.
- Idle counter:
  - Clears on any pop, and whenever idx==0.
  - Otherwise increments each cycle.
  - When it reaches TIMEOUT-1 with idx>0 and no pop that cycle: next cycle HOLD, out_valid=1, out_cnt=idx.
  - So the emit occurs exactly TIMEOUT cycles after the last pop.
- flush=1 with idx>0: next cycle HOLD with out_cnt = idx after any same-cycle pop.
  - If that pop completed the beat, out_cnt=PACK.
- flush=1 with idx==0 and no pop: ignored.
- flush=1 with idx==0 and a same-cycle pop: emits a 1-lane beat.
- Unused lanes of a partial beat read as 0.

HOLD:
- rinc=0; out_data/out_cnt held stable while out_valid=1 and !out_ready.
- On handshake:
  - Next cycle: out_valid=0, out_data cleared to 0, out_cnt=0, state=FILL.
  - No pop in the handshake cycle, giving one bubble.
  - Peak throughput: one full beat per PACK+1 cycles with out_ready tied high.
- flush and timeout are ignored in HOLD; the idle counter is held at 0.

Other rules:
- out_valid never drops without a handshake, except on reset.
- Reset asserted mid-beat discards the partial beat and any held beat; no output after release until new pops.
- Word order is preserved: the first popped word goes to lane 0.

Test Plan:
1. Reset then FIFO holds 8 words 0x11..0x88, out_ready=1 -> two beats: out_data=0x44332211 cnt=4, then 0x88776655 cnt=4; rinc high for exactly 8 edges; 1 bubble between beats.
2. Beat complete, out_ready=0 for 10 cycles -> out_valid and out_data stable for all 10, rinc=0 though rempty=0; accepted on the 11th, next pop the following cycle.
3. Pop 0xA1,0xB2 then rempty=1 -> out_valid rises exactly 16 cycles after the last pop with out_data=0x0000B2A1, cnt=2.
4. Pop 0xC3, then flush=1 on the same edge as a pop of 0xD4 -> next cycle out_data=0x0000D4C3, cnt=2; flush with idx==0 and rempty=1 produces no beat.
5. Three words popped, then rrst pulsed asynchronously mid-cycle -> out_valid=0, rinc=0 immediately; after release, 4 new words 0x01..0x04 give 0x04030201 cnt=4, with no stale lanes.
6. Random rempty and out_ready over 1000 words with a reference model -> every word appears once, in order; out_cnt sums to 1000; rinc never asserted with rempty=1.

Source files
------------

// File: rtl/fifo_read_packer.sv
// Packs PACK consecutive FIFO words into one wide beat on a valid/ready port.
// A partial beat goes out on flush or after TIMEOUT idle cycles.
// Ports:
//   rclk, rrst         read-domain clock, async active-high reset
//   rempty, rdata      FWFT FIFO head (rdata valid when rempty=0)
//   rinc               pop strobe (combinational from state/rempty/rrst)
//   flush              emit the current partial beat
//   out_data, out_cnt  packed beat, number of valid lanes
//   out_valid/ready    output handshake
module fifo_read_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK       = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                           rclk,
  input  logic                           rrst,
  input  logic                           rempty,
  input  logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rinc,
  input  logic                           flush,
  output logic [DATA_WIDTH*PACK-1:0]     out_data,
  output logic [$clog2(PACK+1)-1:0]      out_cnt,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int unsigned IDX_W  = $clog2(PACK);
  localparam int unsigned CNT_W  = $clog2(PACK + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT);
  localparam int unsigned BEAT_W = DATA_WIDTH * PACK;

  typedef enum logic {FILL, HOLD} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]   idle_q, idle_d;
  logic [BEAT_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               pop;
  logic [CNT_W-1:0]   cnt_after;

  // Pop whenever filling and the FIFO has a word; suppressed while in reset.
  assign pop  = (state_q == FILL) && !rempty && !rrst;
  assign rinc = pop;

  // Lanes fill in place; the accumulator doubles as the output register, so
  // lanes past the fill point are still zero from the last clear.
  assign out_data  = data_q;
  assign out_cnt   = cnt_q;
  assign out_valid = valid_q;

  // Lane count including a pop happening this cycle.
  assign cnt_after = CNT_W'(idx_q) + CNT_W'(pop);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    idle_d  = idle_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;

    case (state_q)
      FILL: begin
        if (pop) begin
          for (int unsigned i = 0; i < PACK; i++) begin
            if (idx_q == IDX_W'(i)) data_d[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
          end
          idx_d = idx_q + IDX_W'(1);
        end

        if (pop && (idx_q == IDX_W'(PACK - 1))) begin
          state_d = HOLD;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(PACK);
          idx_d   = '0;
          idle_d  = '0;
        end else if (flush && (cnt_after != '0)) begin
          state_d = HOLD;
          valid_d = 1'b1;
          cnt_d   = cnt_after;
          idx_d   = '0;
          idle_d  = '0;
        end else if (!pop && (idx_q != '0) && (idle_q == TMO_W'(TIMEOUT - 1))) begin
          // Fires TIMEOUT cycles after the last pop.
          state_d = HOLD;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(idx_q);
          idx_d   = '0;
          idle_d  = '0;
        end else if (pop || (idx_q == '0)) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + TMO_W'(1);
        end
      end

      HOLD: begin
        idle_d = '0;
        if (out_ready) begin
          state_d = FILL;
          valid_d = 1'b0;
          data_d  = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= FILL;
      idx_q   <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Self-checking bench for fifo_read_packer: a FIFO model drives the read
// port, stimulus pushes expected beats/words into queues, and a monitor
// compares every accepted output beat against them.
module tb_fifo_read_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned PK = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned BW = DW * PK;

  logic          rclk;
  logic          rrst;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          flush;
  logic [BW-1:0] out_data;
  logic [CW-1:0] out_cnt;
  logic          out_valid;
  logic          out_ready;

  fifo_read_packer #(.DATA_WIDTH(DW), .PACK(PK), .TIMEOUT(16)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo[$];
  logic          stall = 1'b0;
  logic          last_p;

  logic [BW-1:0] exp_data[$];
  logic [CW-1:0] exp_cnt[$];
  logic [DW-1:0] exp_w[$];
  logic          word_mode = 1'b0;
  int            cnt_sum = 0;
  int            rinc_viol = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    rempty = stall || (fifo.size() == 0);
    rdata  = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo.push_back(w);
    refresh();
  endtask

  task automatic expect_beat(input logic [BW-1:0] d, input logic [CW-1:0] c);
    exp_data.push_back(d);
    exp_cnt.push_back(c);
  endtask

  // One clock: sample rinc away from the edge, consume the head if popped.
  task automatic tick();
    logic [DW-1:0] tmp;
    @(negedge rclk);
    last_p = rinc;
    @(posedge rclk);
    if (last_p && fifo.size() != 0) tmp = fifo.pop_front();
    #1;
    refresh();
  endtask

  // Monitor: compare every accepted beat against the scoreboard.
  always @(negedge rclk) begin
    if (!rrst) begin
      if (rinc && rempty) rinc_viol++;
      if (out_valid && out_ready) begin
        if (!word_mode) begin
          if (exp_data.size() == 0) begin
            chk("unexpected_beat", {29'd0, out_cnt, out_data}, 64'd0);
          end else begin
            chk("beat_data", 64'(out_data), 64'(exp_data.pop_front()));
            chk("beat_cnt", 64'(out_cnt), 64'(exp_cnt.pop_front()));
          end
        end else begin
          logic ok;
          logic [DW-1:0] lane;
          ok = (out_cnt != '0) && (out_cnt <= CW'(PK));
          cnt_sum += int'(out_cnt);
          for (int l = 0; l < int'(PK); l++) begin
            lane = out_data[l*DW +: DW];
            if (l < int'(out_cnt)) begin
              if (exp_w.size() == 0) ok = 1'b0;
              else if (lane !== exp_w.pop_front()) ok = 1'b0;
            end else if (lane !== '0) begin
              ok = 1'b0;
            end
          end
          chk("word_order", {63'd0, ok}, 64'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] pat;
    int n;
    int n_pushed;
    int cyc;
    logic [DW-1:0] w;

    rrst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    refresh();
    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_cnt", 64'(out_cnt), 64'd0);
    chk("rst_rinc", 64'(rinc), 64'd0);
    @(posedge rclk); @(posedge rclk); #1;
    rrst = 1'b0;

    // Two back-to-back full beats.
    out_ready = 1'b1;
    expect_beat(32'h44332211, 3'd4);
    expect_beat(32'h88776655, 3'd4);
    for (int i = 1; i <= 8; i++) push_word(DW'(i * 8'h11));
    pat = '0;
    for (int i = 0; i < 14; i++) begin
      tick();
      pat[i] = last_p;
    end
    chk("rinc_pattern", 64'(pat), 64'h01EF);

    // Backpressure for 10 cycles while the FIFO still has data.
    out_ready = 1'b0;
    expect_beat(32'h24232221, 3'd4);
    expect_beat(32'h00000025, 3'd1);
    for (int i = 1; i <= 5; i++) push_word(DW'(8'h20 + i));
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      chk("hold_stable",
          {30'd0, out_valid, rinc, out_data},
          {30'd0, 1'b1, 1'b0, 32'h24232221});
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("after_accept", {62'd0, out_valid, rinc}, {62'd0, 1'b0, 1'b1});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();

    // Timeout on a two-word partial beat.
    expect_beat(32'h0000B2A1, 3'd2);
    push_word(8'hA1);
    push_word(8'hB2);
    tick();
    tick();
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_latency", 64'(n), 64'd16);
    tick();

    // Flush together with a pop, then flush with nothing buffered.
    expect_beat(32'h0000D4C3, 3'd2);
    push_word(8'hC3);
    tick();
    push_word(8'hD4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_emit", {60'd0, out_valid, out_cnt}, {60'd0, 1'b1, 3'd2});
    tick();
    flush = 1'b1;
    tick();
    chk("flush_empty_1", 64'(out_valid), 64'd0);
    tick();
    tick();
    flush = 1'b0;
    chk("flush_empty_3", 64'(out_valid), 64'd0);

    // Reset in the middle of a partial beat.
    push_word(8'h91);
    push_word(8'h92);
    push_word(8'h93);
    for (int i = 0; i < 3; i++) tick();
    push_word(8'h01);
    #2;
    rrst = 1'b1;
    #1;
    chk("midrst_outputs", {28'd0, out_valid, rinc, out_cnt, out_data}, 64'd0);
    tick();
    rrst = 1'b0;
    expect_beat(32'h04030201, 3'd4);
    push_word(8'h02);
    push_word(8'h03);
    push_word(8'h04);
    for (int i = 0; i < 6; i++) tick();
    chk("directed_drained", 64'(exp_data.size()), 64'd0);

    // Random stalls and backpressure over 1000 words.
    word_mode = 1'b1;
    n_pushed = 0;
    cyc = 0;
    while ((n_pushed < 1000 || exp_w.size() != 0) && cyc < 15000) begin
      stall     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (n_pushed < 1000 && fifo.size() < 4) begin
        w = DW'($urandom_range(0, 255));
        fifo.push_back(w);
        exp_w.push_back(w);
        n_pushed++;
      end
      refresh();
      tick();
      cyc++;
    end
    chk("random_words_left", 64'(exp_w.size()), 64'd0);
    chk("random_cnt_sum", 64'(cnt_sum), 64'd1000);
    chk("rinc_while_empty", 64'(rinc_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
